// File: rtl/dct8_pipe_if.sv
// dct8_pipe_if: stream bundle for the 8-point DCT pipeline.
// Carries the input beat (pass_sel, in_valid/in_ready, in_data) and the
// output beat (out_valid/out_ready, out_data, out_sat, out_row, out_last).
//   master : beat producer and consumer (drives inputs, takes results)
//   slave  : the DCT block
// Parameters IN_W / OUT_W must match the attached dct8_pipe instance.
interface dct8_pipe_if #(
  parameter int unsigned IN_W  = 8,
  parameter int unsigned OUT_W = 8
);
  logic                 pass_sel;
  logic                 in_valid;
  logic                 in_ready;
  logic [8*IN_W-1:0]    in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [8*OUT_W-1:0]   out_data;
  logic                 out_sat;
  logic [2:0]           out_row;
  logic                 out_last;

  modport master (
    output pass_sel, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sat, out_row, out_last
  );

  modport slave (
    input  pass_sel, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sat, out_row, out_last
  );
endinterface

// File: rtl/dct8_pipe.sv
// dct8_pipe: pipelined 8-point 1-D forward DCT (JPEG transform path).
// Input capture register, then three registered stages:
//   stage 1 butterflies, stage 2 constant multiplies, stage 3 round/clamp.
// Beat accepted at edge N is presented with out_valid=1 after edge N+3.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : dct8_pipe_if.slave
//            pass_sel (0=row, 1=column), in_valid/in_ready, in_data (x0 in MSBs),
//            out_valid/out_ready, out_data (y0 in MSBs), out_sat, out_row, out_last
// Optional feature macro: DCT_LEVEL_SHIFT_EN
//   defined   : row-pass samples are unsigned and have 2^(IN_W-1) subtracted first
//   undefined : samples are always signed, no offset logic
module dct8_pipe #(
  parameter int unsigned IN_W      = 8,
  parameter int unsigned OUT_W     = 8,
  parameter int unsigned SHIFT_ROW = 7,
  parameter int unsigned SHIFT_COL = 9
) (
  input logic        clk,
  input logic        rst_n,
  dct8_pipe_if.slave bus
);
  localparam int unsigned W0 = IN_W + 1;   // sample after optional level shift
  localparam int unsigned W1 = IN_W + 3;   // butterfly outputs
  localparam int unsigned W2 = IN_W + 10;  // products and sums
  localparam int unsigned W3 = W2 + 1;     // room for the rounding offset

  localparam logic signed [W2-1:0] K1 = W2'(63);
  localparam logic signed [W2-1:0] K2 = W2'(59);
  localparam logic signed [W2-1:0] K3 = W2'(53);
  localparam logic signed [W2-1:0] K4 = W2'(45);
  localparam logic signed [W2-1:0] K5 = W2'(36);
  localparam logic signed [W2-1:0] K6 = W2'(24);
  localparam logic signed [W2-1:0] K7 = W2'(12);

  localparam logic signed [W3-1:0] RND_ROW = W3'(2 ** (SHIFT_ROW - 1));
  localparam logic signed [W3-1:0] RND_COL = W3'(2 ** (SHIFT_COL - 1));
  localparam logic signed [W3-1:0] MAXV    = W3'(2 ** (OUT_W - 1) - 1);
  localparam logic signed [W3-1:0] MINV    = ~MAXV;

  function automatic logic signed [W1-1:0] e1(input logic [W0-1:0] v);
    return W1'($signed(v));
  endfunction

  function automatic logic signed [W2-1:0] e2(input logic [W1-1:0] v);
    return W2'($signed(v));
  endfunction

  // Handshake: a stalled output freezes every stage, otherwise all advance.
  logic w_stall, w_adv, w_in_xfer;
  logic r_out_valid;

  assign w_stall   = r_out_valid && !bus.out_ready;
  assign w_adv     = !w_stall;
  assign w_in_xfer = bus.in_valid && w_adv;

  // Input capture with beat index and pass tag.
  logic [2:0]          r_beat;
  logic                r_in_valid, r_in_pass;
  logic [2:0]          r_in_row;
  logic [8*IN_W-1:0]   r_in_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat     <= '0;
      r_in_valid <= 1'b0;
      r_in_pass  <= 1'b0;
      r_in_row   <= '0;
      r_in_data  <= '0;
    end else begin
      if (w_in_xfer) r_beat <= r_beat + 3'd1;
      if (w_adv) begin
        r_in_valid <= bus.in_valid;
        if (bus.in_valid) begin
          r_in_data <= bus.in_data;
          r_in_pass <= bus.pass_sel;
          r_in_row  <= r_beat;
        end
      end
    end
  end

  // Stage 1: sample extraction (x_k in element k) and butterflies.
  logic [7:0][W0-1:0] w_x;
  logic [7:0][W1-1:0] w_a;
  logic [3:0][W1-1:0] w_b;

`ifdef DCT_LEVEL_SHIFT_EN
  localparam logic [W0-1:0] LVL = W0'(2 ** (IN_W - 1));
`endif

  always_comb begin
    w_x = '0;
    for (int k = 0; k < 8; k++) begin
`ifdef DCT_LEVEL_SHIFT_EN
      if (!r_in_pass) w_x[k] = {1'b0, r_in_data[(7-k)*IN_W +: IN_W]} - LVL;
      else            w_x[k] = W0'($signed(r_in_data[(7-k)*IN_W +: IN_W]));
`else
      w_x[k] = W0'($signed(r_in_data[(7-k)*IN_W +: IN_W]));
`endif
    end
  end

  always_comb begin
    w_a = '0;
    w_b = '0;
    for (int k = 0; k < 4; k++) begin
      w_a[k]   = e1(w_x[k]) + e1(w_x[7-k]);
      w_a[k+4] = e1(w_x[k]) - e1(w_x[7-k]);
    end
    w_b[0] = w_a[0] + w_a[3];
    w_b[1] = w_a[1] + w_a[2];
    w_b[2] = w_a[0] - w_a[3];
    w_b[3] = w_a[1] - w_a[2];
  end

  logic               r_s1_valid, r_s1_pass;
  logic [2:0]         r_s1_row;
  logic [3:0][W1-1:0] r_s1_b;  // b1..b4
  logic [3:0][W1-1:0] r_s1_d;  // a5..a8

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_pass  <= 1'b0;
      r_s1_row   <= '0;
      r_s1_b     <= '0;
      r_s1_d     <= '0;
    end else if (w_adv) begin
      r_s1_valid <= r_in_valid;
      r_s1_pass  <= r_in_pass;
      r_s1_row   <= r_in_row;
      r_s1_b     <= w_b;
      r_s1_d     <= w_a[7:4];
    end
  end

  // Stage 2: constant multiplies.
  logic [7:0][W2-1:0] w_y;

  always_comb begin
    w_y    = '0;
    w_y[0] = K4 * (e2(r_s1_b[0]) + e2(r_s1_b[1]));
    w_y[4] = K4 * (e2(r_s1_b[0]) - e2(r_s1_b[1]));
    w_y[2] = K2 * e2(r_s1_b[2]) + K6 * e2(r_s1_b[3]);
    w_y[6] = K6 * e2(r_s1_b[2]) - K2 * e2(r_s1_b[3]);
    w_y[1] = K1 * e2(r_s1_d[0]) + K3 * e2(r_s1_d[1])
           + K5 * e2(r_s1_d[2]) + K7 * e2(r_s1_d[3]);
    w_y[3] = K3 * e2(r_s1_d[0]) - K7 * e2(r_s1_d[1])
           - K1 * e2(r_s1_d[2]) - K5 * e2(r_s1_d[3]);
    w_y[5] = K5 * e2(r_s1_d[0]) - K1 * e2(r_s1_d[1])
           + K7 * e2(r_s1_d[2]) + K3 * e2(r_s1_d[3]);
    w_y[7] = K7 * e2(r_s1_d[0]) - K5 * e2(r_s1_d[1])
           + K3 * e2(r_s1_d[2]) - K1 * e2(r_s1_d[3]);
  end

  logic               r_s2_valid, r_s2_pass;
  logic [2:0]         r_s2_row;
  logic [7:0][W2-1:0] r_s2_y;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_pass  <= 1'b0;
      r_s2_row   <= '0;
      r_s2_y     <= '0;
    end else if (w_adv) begin
      r_s2_valid <= r_s1_valid;
      r_s2_pass  <= r_s1_pass;
      r_s2_row   <= r_s1_row;
      r_s2_y     <= w_y;
    end
  end

  // Stage 3: round half up, arithmetic shift, clamp.
  logic [8*OUT_W-1:0]    w_res;
  logic                  w_sat;
  logic signed [W3-1:0]  w_sum, w_shf;

  always_comb begin
    w_res = '0;
    w_sat = 1'b0;
    w_sum = '0;
    w_shf = '0;
    for (int k = 0; k < 8; k++) begin
      w_sum = W3'($signed(r_s2_y[k])) + (r_s2_pass ? RND_COL : RND_ROW);
      w_shf = r_s2_pass ? (w_sum >>> SHIFT_COL) : (w_sum >>> SHIFT_ROW);
      if (w_shf > MAXV) begin
        w_res[(7-k)*OUT_W +: OUT_W] = MAXV[OUT_W-1:0];
        w_sat = 1'b1;
      end else if (w_shf < MINV) begin
        w_res[(7-k)*OUT_W +: OUT_W] = MINV[OUT_W-1:0];
        w_sat = 1'b1;
      end else begin
        w_res[(7-k)*OUT_W +: OUT_W] = w_shf[OUT_W-1:0];
      end
    end
  end

  logic [8*OUT_W-1:0] r_out_data;
  logic               r_out_sat, r_out_last;
  logic [2:0]         r_out_row;

  // Output fields load only with a valid beat so they stay quiet across bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sat   <= 1'b0;
      r_out_row   <= '0;
      r_out_last  <= 1'b0;
    end else if (w_adv) begin
      r_out_valid <= r_s2_valid;
      if (r_s2_valid) begin
        r_out_data <= w_res;
        r_out_sat  <= w_sat;
        r_out_row  <= r_s2_row;
        r_out_last <= (r_s2_row == 3'd7);
      end
    end
  end

  assign bus.in_ready  = !w_stall;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_sat   = r_out_sat;
  assign bus.out_row   = r_out_row;
  assign bus.out_last  = r_out_last;
endmodule

// File: tb/tb_dct8_pipe.sv
// Bench for dct8_pipe: fixed vector table with hand-derived results, mid-block
// reset, backpressure hold and a random stream scored against a matrix-form DCT model.
module tb_dct8_pipe;
  localparam int unsigned IN_W  = 8;
  localparam int unsigned OUT_W = 8;
`ifdef DCT_LEVEL_SHIFT_EN
  localparam bit LS = 1'b1;
`else
  localparam bit LS = 1'b0;
`endif

  typedef struct packed {
    logic [63:0] data;
    logic        sat;
    logic [2:0]  row;
    logic        last;
  } exp_t;

  typedef struct {
    logic [63:0] xs;    // signed-domain samples, x0 in MSBs
    logic        pass;
    logic [63:0] y;
    logic        sat;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dct8_pipe_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  dct8_pipe #(
    .IN_W(IN_W), .OUT_W(OUT_W), .SHIFT_ROW(7), .SHIFT_COL(9)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int   checks = 0, failures = 0;
  exp_t exp_q[$];
  int   model_beat = 0, n_out = 0, n_last = 0, n_stall = 0;
  bit   held_prev = 1'b0;
  logic [63:0] held_data;
  logic [4:0]  held_meta;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [63:0] pk(input int a0, input int a1, input int a2, input int a3,
                                     input int a4, input int a5, input int a6, input int a7);
    return {a0[7:0], a1[7:0], a2[7:0], a3[7:0], a4[7:0], a5[7:0], a6[7:0], a7[7:0]};
  endfunction

  // Row-pass samples become unsigned (offset by 128) when the level shift is built in.
  function automatic logic [63:0] to_raw(input logic [63:0] xs, input logic pass);
    return (pass || !LS) ? xs : (xs ^ {8{8'h80}});
  endfunction

  // DCT as a matrix product: coefficient (k,n) is the scaled cosine of k(2n+1)pi/16.
  function automatic exp_t model(input logic [63:0] din, input logic pass, input int beat);
    int     kc [9];
    int     x [8];
    longint y;
    int     m, sg, s, r;
    logic [7:0] b;
    exp_t   e;
    kc = '{45, 63, 59, 53, 45, 36, 24, 12, 0};
    e  = '0;
    s  = pass ? 9 : 7;
    for (int n = 0; n < 8; n++) begin
      b    = din[(7-n)*8 +: 8];
      x[n] = (!pass && LS) ? (int'(b) - 128) : int'($signed(b));
    end
    for (int k = 0; k < 8; k++) begin
      y = 0;
      for (int n = 0; n < 8; n++) begin
        m  = (k * (2 * n + 1)) % 32;
        sg = 1;
        if (m > 16) m = 32 - m;
        if (m > 8) begin
          sg = -1;
          m  = 16 - m;
        end
        y += longint'(sg * kc[m] * x[n]);
      end
      y = (y + (longint'(1) <<< (s - 1))) >>> s;
      if (y > 127) begin
        y = 127;
        e.sat = 1'b1;
      end else if (y < -128) begin
        y = -128;
        e.sat = 1'b1;
      end
      r = int'(y);
      e.data[(7-k)*8 +: 8] = r[7:0];
    end
    e.row  = beat[2:0];
    e.last = (beat == 7);
    return e;
  endfunction

  // Scoreboard and stall monitor, sampled mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      exp_q.delete();
      model_beat = 0;
      held_prev  = 1'b0;
    end else begin
      if (bus.out_valid && !bus.out_ready) begin
        n_stall++;
        chk("stall_in_ready", 64'(bus.in_ready), 64'(0));
        if (held_prev) begin
          chk("stall_hold_data", bus.out_data, held_data);
          chk("stall_hold_meta", 64'({bus.out_sat, bus.out_row, bus.out_last}),
              64'(held_meta));
        end
        held_prev = 1'b1;
        held_data = bus.out_data;
        held_meta = {bus.out_sat, bus.out_row, bus.out_last};
      end else begin
        held_prev = 1'b0;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected_out actual=%0h required=none", bus.out_data);
        end else begin
          e = exp_q.pop_front();
          chk("sb_data", bus.out_data, e.data);
          chk("sb_sat", 64'(bus.out_sat), 64'(e.sat));
          chk("sb_row", 64'(bus.out_row), 64'(e.row));
          chk("sb_last", 64'(bus.out_last), 64'(e.last));
          n_out++;
          if (bus.out_last) n_last++;
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(model(bus.in_data, bus.pass_sel, model_beat));
        model_beat = (model_beat + 1) % 8;
      end
    end
  end

  // Hold a beat until it is accepted; called just after a rising edge.
  task automatic send(input logic [63:0] d, input logic p, output bit ok);
    bit acc;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.pass_sel = p;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      if (acc) ok = 1'b1;
    end
    bus.in_valid = 1'b0;
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=not_accepted required=accepted");
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [10];
    int   lat;
    bit   got, ok, hold_done, drv_done;

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.pass_sel  = 1'b0;
    bus.out_ready = 1'b1;

    tbl[0] = '{pk(100, 0, 0, 0, 0, 0, 0, 0), 1'b0, pk(35, 49, 46, 41, 35, 28, 19, 9), 1'b0};
    tbl[1] = '{pk(10, 10, 10, 10, 10, 10, 10, 10), 1'b0, pk(28, 0, 0, 0, 0, 0, 0, 0), 1'b0};
    tbl[2] = '{pk(10, 10, 10, 10, 10, 10, 10, 10), 1'b1, pk(7, 0, 0, 0, 0, 0, 0, 0), 1'b0};
    tbl[3] = '{pk(127, 127, 127, 127, 127, 127, 127, 127), 1'b0,
               pk(127, 0, 0, 0, 0, 0, 0, 0), 1'b1};
    tbl[4] = '{pk(-128, -128, -128, -128, -128, -128, -128, -128), 1'b0,
               pk(-128, 0, 0, 0, 0, 0, 0, 0), 1'b1};
    tbl[5] = '{pk(100, 0, 0, 0, 0, 0, 0, 0), 1'b1, pk(9, 12, 12, 10, 9, 7, 5, 2), 1'b0};
    tbl[6] = '{pk(-100, 0, 0, 0, 0, 0, 0, 0), 1'b0,
               pk(-35, -49, -46, -41, -35, -28, -19, -9), 1'b0};
    tbl[7] = '{pk(8, 8, 8, 8, 8, 8, 8, 8), 1'b0, pk(23, 0, 0, 0, 0, 0, 0, 0), 1'b0};
    tbl[8] = '{pk(-8, -8, -8, -8, -8, -8, -8, -8), 1'b0, pk(-22, 0, 0, 0, 0, 0, 0, 0), 1'b0};
    tbl[9] = '{pk(127, 127, 127, 127, 127, 127, 127, 127), 1'b1,
               pk(89, 0, 0, 0, 0, 0, 0, 0), 1'b0};

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_out_data", bus.out_data, 64'(0));
    chk("rst_out_sat", 64'(bus.out_sat), 64'(0));
    chk("rst_out_row", 64'(bus.out_row), 64'(0));
    chk("rst_out_last", 64'(bus.out_last), 64'(0));
    rst_n = 1'b1;
    #1 chk("rst_in_ready", 64'(bus.in_ready), 64'(1));

    // Vector table: one beat at a time, latency plus hand-derived results
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      bus.in_valid = 1'b1;
      bus.pass_sel = tbl[i].pass;
      bus.in_data  = to_raw(tbl[i].xs, tbl[i].pass);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      lat = 0;
      got = 1'b0;
      for (int c = 0; c < 10 && !got; c++) begin
        @(negedge clk);
        if (bus.out_valid) got = 1'b1;
        else lat++;
      end
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(3));
      chk($sformatf("vec%0d_data", i), bus.out_data, tbl[i].y);
      chk($sformatf("vec%0d_sat", i), 64'(bus.out_sat), 64'(tbl[i].sat));
      chk($sformatf("vec%0d_row", i), 64'(bus.out_row), 64'(i % 8));
      chk($sformatf("vec%0d_last", i), 64'(bus.out_last), 64'((i % 8) == 7));
    end

    // Reset mid-block
    @(posedge clk);
    #1 do_reset();
    for (int j = 0; j < 3; j++) begin
      send(64'({$urandom, $urandom}), 1'($urandom_range(0, 1)), ok);
    end
    @(posedge clk);
    #1 chk("mid_pre_valid", 64'(bus.out_valid), 64'(1));
    #2 rst_n = 1'b0;
    #1 chk("mid_rst_valid", 64'(bus.out_valid), 64'(0));
    chk("mid_rst_row", 64'(bus.out_row), 64'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    send(to_raw(pk(100, 0, 0, 0, 0, 0, 0, 0), 1'b0), 1'b0, ok);
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk);
      if (bus.out_valid) got = 1'b1;
    end
    chk("mid_next_seen", 64'(got), 64'(1));
    chk("mid_next_row", 64'(bus.out_row), 64'(0));
    chk("mid_next_data", bus.out_data, pk(35, 49, 46, 41, 35, 28, 19, 9));

    // Backpressure: 16 beats with random gaps, one 5-cycle hold on a valid output
    @(posedge clk);
    #1 do_reset();
    n_out     = 0;
    n_last    = 0;
    n_stall   = 0;
    hold_done = 1'b0;
    fork
      begin
        for (int j = 0; j < 16; j++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
          send(64'({$urandom, $urandom}), 1'($urandom_range(0, 1)), ok);
        end
      end
      begin
        for (int c = 0; c < 80; c++) begin
          @(posedge clk);
          #1;
          if (!hold_done && c >= 8 && bus.out_valid) begin
            bus.out_ready = 1'b0;
            repeat (5) @(posedge clk);
            #1 bus.out_ready = 1'b1;
            hold_done = 1'b1;
          end
        end
      end
    join
    for (int c = 0; c < 50 && n_out < 16; c++) @(negedge clk);
    chk("bp_hold_applied", 64'(hold_done), 64'(1));
    chk("bp_stall_cycles", 64'(n_stall), 64'(5));
    chk("bp_out_count", 64'(n_out), 64'(16));
    chk("bp_last_count", 64'(n_last), 64'(2));
    chk("bp_queue_empty", 64'(exp_q.size()), 64'(0));

    // Random stream with random backpressure
    drv_done = 1'b0;
    n_out    = 0;
    fork
      begin
        for (int j = 0; j < 300; j++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
          send(64'({$urandom, $urandom}), 1'($urandom_range(0, 1)), ok);
        end
        drv_done = 1'b1;
      end
      begin
        while (!drv_done) begin
          @(posedge clk);
          #1 bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        bus.out_ready = 1'b1;
      end
    join
    for (int c = 0; c < 50 && exp_q.size() != 0; c++) @(negedge clk);
    chk("rnd_out_count", 64'(n_out), 64'(300));
    chk("rnd_queue_empty", 64'(exp_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dct8_pipe.md
Name: dct8_pipe

Overview:
- Pipelined, parametrised 8-point 1-D forward DCT for the JPEG transform path.
- Successor to the combinational shift-add DCT stage:
  - registered 3-stage pipeline with valid/ready handshake
  - generic sample widths
  - selectable row/column pass with independent output scaling
  - round-half-up and saturation
  - per-block beat counter
- Two instances (or one time-shared) with a transpose buffer form the 2-D DCT.

Parameters:
- IN_W, 8, signed input sample width
- OUT_W, 8, signed output coefficient width
- SHIFT_ROW, 7, right shift applied to products when pass_sel=0
- SHIFT_COL, 9, right shift applied to products when pass_sel=1

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- pass_sel  in  1  0=row pass, 1=column pass; sampled with each accepted beat
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat this cycle
- in_data  in  8*IN_W  x0 in MSBs … x7 in LSBs
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts
- out_data  out  8*OUT_W  y0 in MSBs … y7 in LSBs
- out_sat  out  1  one or more coefficients of this beat saturated
- out_row  out  3  beat index within the 8-beat block
- out_last  out  1  high on beat with out_row==7

Behaviour:
- Reset (async, rst_n=0):
  - all valid flags, out_data, out_sat, out_row, out_last and the beat counter clear to 0
  - in_ready=1 after reset deasserts
  - reset mid-block discards all in-flight beats; the next accepted beat is row 0
- Handshake:
  - input transfer when in_valid&&in_ready; output transfer when out_valid&&out_ready
  - stall = out_valid && !out_ready; in_ready = !stall
  - on stall all three stages hold; otherwise all advance (bubbles propagate)
  - out_data, out_sat, out_row, out_last are stable while out_valid && !out_ready
- Latency: beat accepted at edge N appears with out_valid=1 after edge N+3 when unstalled. Throughput 1 beat/cycle.
- Stage 1, butterflies, sign-extended, no truncation:
  - a1=x0+x7, a2=x1+x6, a3=x2+x5, a4=x3+x4
  - a5=x0-x7, a6=x1-x6, a7=x2-x5, a8=x3-x4
  - b1=a1+a4, b2=a2+a3, b3=a1-a4, b4=a2-a3
  - beat counter (0..7, wraps) and pass_sel are tagged onto the beat
- Stage 2, constant multiplies:
  - constants K1=63, K2=59, K3=53, K4=45, K5=36, K6=24, K7=12
  - y0=K4*(b1+b2); y4=K4*(b1-b2)
  - y2=K2*b3+K6*b4; y6=K6*b3-K2*b4
  - y1=K1*a5+K3*a6+K5*a7+K7*a8
  - y3=K3*a5-K7*a6-K1*a7-K5*a8
  - y5=K5*a5-K1*a6+K7*a7+K3*a8
  - y7=K7*a5-K5*a6+K3*a7-K1*a8
  - internal width IN_W+10; no overflow is possible
- Stage 3, scaling:
  - S = pass_sel ? SHIFT_COL : SHIFT_ROW
  - r = (y + 2^(S-1)) >>> S (round half up)
  - clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1]
  - out_sat = OR of all eight clamp events
- Beat counter:
  - increments only on input transfer; wraps 7→0
  - out_last = (out_row==7)
  - a pass_sel change mid-block is honoured per beat and does not reset the counter

Optional Feature:
- Macro: DCT_LEVEL_SHIFT_EN
- Defined: when pass_sel=0, each input sample is treated as unsigned and 2^(IN_W-1) is subtracted before stage 1 (JPEG level shift); column pass is unaffected.
- Undefined: inputs are always signed, with no offset logic.

Test Plan:
- Impulse, row pass, feature off: x0=100, others 0 → y0..y7 = 35,49,46,41,35,28,19,9; out_sat=0; first output 3 cycles after acceptance.
- DC, row pass: all x=10 → y0=28, others 0. Same input, column pass → y0=7.
- Saturation: all x=127, row pass → y0=127, out_sat=1, y1..y7=0. All x=-128 → y0=-128, out_sat=1.
- Backpressure: stream 16 beats with random in_valid; hold out_ready=0 for 5 cycles mid-stream → in_ready=0 during the hold, no loss/duplication/change of held output, out_last on beats 8 and 16.
- Reset mid-block: assert rst_n=0 after 3 accepted beats → out_valid=0 immediately; the next accepted beat emerges with out_row=0.
- DCT_LEVEL_SHIFT_EN defined: all x=128 (unsigned), row pass → all outputs 0. x0=228, others 128 → impulse vector as in the first scenario.
